// File: rtl/iosys_tx_sched_if.sv
// Byte-stream bus between the iosys message sources, the TX scheduler and the
// UART transmitter. The slave view is the scheduler; the master view is everything around it.
interface iosys_tx_sched_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   src_valid;
  logic [8*NREQ-1:0] src_data;
  logic [NREQ-1:0]   src_last;
  logic [NREQ-1:0]   src_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport slave (
    input  src_valid, src_data, src_last, tx_busy,
    output src_ready, tx_data, tx_start
  );

  modport master (
    output src_valid, src_data, src_last, tx_busy,
    input  src_ready, tx_data, tx_start
  );
endinterface

// File: rtl/iosys_tx_sched.sv
// Round-robin packet scheduler sharing one UART transmitter between NREQ byte
// sources. It sends whole packets only, with an idle gap between packets and an abort when a source stalls.
module iosys_tx_sched #(
  parameter int NREQ       = 3,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic            clk,
  input  logic            resetn,
  iosys_tx_sched_if.slave bus,
  output logic            grant_valid_o,
  output logic [2:0]      grant_idx_o,
  output logic            err_timeout_o
);
  // state | meaning
  // IDLE  | no grant; arbitrate among valid sources from rr_ptr
  // SEND  | granted source may hand over its next byte
  // WAIT  | one cycle for the transmitter busy flag to rise
  // GAP   | enforced idle time after a packet or an abort

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  localparam state_t REL_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t           state_q;
  logic [2:0]       grant_idx_q;
  logic [2:0]       rr_ptr_q;
  logic             grant_valid_q;
  logic             tx_start_q;
  logic             err_timeout_q;
  logic             last_flag_q;
  logic [7:0]       tx_data_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;

  logic [NREQ-1:0]  gnt_oh;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             accept;
  logic             pick_found;
  logic [2:0]       pick_idx;
  logic [3:0]       pos;
  logic [2:0]       rr_ptr_d;
  logic [TO_W-1:0]  to_cnt_d;

  always_comb begin
    gnt_oh  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = (grant_idx_q == 3'(i));
      if (gnt_oh[i]) begin
        g_valid = bus.src_valid[i];
        g_last  = bus.src_last[i];
        g_data  = bus.src_data[8*i +: 8];
      end
    end
  end

  assign accept        = (state_q == SEND) && g_valid && !bus.tx_busy;
  assign bus.src_ready = {NREQ{accept}} & gnt_oh;

  // First valid source at rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = 4'(rr_ptr_q) + 4'(k);
      if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_found && (pos == 4'(i)) && bus.src_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
    rr_ptr_d = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
    to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      last_flag_q   <= 1'b0;
      tx_data_q     <= '0;
      gap_cnt_q     <= '0;
      to_cnt_q      <= '0;
    end else begin
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_idx_q   <= pick_idx;
            grant_valid_q <= 1'b1;
            rr_ptr_q      <= rr_ptr_d;
            to_cnt_q      <= '0;
            state_q       <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            tx_data_q   <= g_data;
            tx_start_q  <= 1'b1;
            last_flag_q <= g_last;
            to_cnt_q    <= '0;
            state_q     <= WAIT;
          end else if (!g_valid && !bus.tx_busy) begin
            // Only source stalls count; waiting on the transmitter is expected.
            if (to_cnt_d == TO_W'(TIMEOUT)) begin
              err_timeout_q <= 1'b1;
              grant_valid_q <= 1'b0;
              to_cnt_q      <= '0;
              gap_cnt_q     <= GAP_W'(GAP_CYCLES);
              state_q       <= REL_STATE;
            end else begin
              to_cnt_q <= to_cnt_d;
            end
          end
        end
        WAIT: begin
          if (last_flag_q) begin
            grant_valid_q <= 1'b0;
            gap_cnt_q     <= GAP_W'(GAP_CYCLES);
            state_q       <= REL_STATE;
          end else begin
            state_q <= SEND;
          end
        end
        GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign grant_valid_o  = grant_valid_q;
  assign grant_idx_o    = grant_idx_q;
  assign err_timeout_o  = err_timeout_q;

endmodule

// File: tb/tb_iosys_tx_sched.sv
// Directed bench for iosys_tx_sched. Per-source packet queues feed two DUTs (16-cycle gap, no gap),
// and scoreboards check every transmitted byte, its source and its spacing.
`timescale 1ns/1ps
module tb_iosys_tx_sched;
  localparam int NREQ   = 3;
  localparam int BUSY_A = 20;
  localparam int BUSY_B = 5;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
    logic [7:0] gap;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iosys_tx_sched_if #(.NREQ(NREQ)) ifa ();
  iosys_tx_sched_if #(.NREQ(NREQ)) ifb ();

  logic       gva, erra, gvb, errb;
  logic [2:0] gia, gib;

  iosys_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(16), .TIMEOUT(100)) dut_a (
    .clk(clk), .resetn(resetn), .bus(ifa),
    .grant_valid_o(gva), .grant_idx_o(gia), .err_timeout_o(erra)
  );

  iosys_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(0), .TIMEOUT(100)) dut_b (
    .clk(clk), .resetn(resetn), .bus(ifb),
    .grant_valid_o(gvb), .grant_idx_o(gib), .err_timeout_o(errb)
  );

  logic [8:0] qa [NREQ][$];
  logic [8:0] qb [NREQ][$];
  exp_t expa_q[$];
  exp_t expb_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_b = 0;
  int busy_a = 0;
  int busy_b = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Transmitter models: busy rises the cycle after tx_start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.tx_start) busy_a <= BUSY_A;
    else if (busy_a > 0) busy_a <= busy_a - 1;
    if (ifb.tx_start) busy_b <= BUSY_B;
    else if (busy_b > 0) busy_b <= busy_b - 1;
  end
  assign ifa.tx_busy = (busy_a != 0);
  assign ifb.tx_busy = (busy_b != 0);

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (ifa.src_valid[i] && ifa.src_ready[i]) void'(qa[i].pop_front());
      if (ifb.src_valid[i] && ifb.src_ready[i]) void'(qb[i].pop_front());
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      ifa.src_valid[i] = (qa[i].size() > 0);
      ifa.src_data[8*i +: 8] = (qa[i].size() > 0) ? qa[i][0][7:0] : 8'h00;
      ifa.src_last[i] = (qa[i].size() > 0) ? qa[i][0][8] : 1'b0;
      ifb.src_valid[i] = (qb[i].size() > 0);
      ifb.src_data[8*i +: 8] = (qb[i].size() > 0) ? qb[i][0][7:0] : 8'h00;
      ifb.src_last[i] = (qb[i].size() > 0) ? qb[i][0][8] : 1'b0;
    end
  end

  // Scoreboard monitors.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.tx_start) begin
      if (expa_q.size() == 0) begin
        check("a_unexpected_tx", int'(ifa.tx_data), -1);
      end else begin
        e = expa_q.pop_front();
        check("a_tx_data", int'(ifa.tx_data), int'(e.data));
        check("a_grant_idx", int'(gia), int'(e.idx));
        check("a_grant_valid", int'(gva), 1);
      end
    end
    if (ifb.tx_start) begin
      if (expb_q.size() == 0) begin
        check("b_unexpected_tx", int'(ifb.tx_data), -1);
      end else begin
        e = expb_q.pop_front();
        check("b_tx_data", int'(ifb.tx_data), int'(e.data));
        check("b_grant_idx", int'(gib), int'(e.idx));
        if (e.gap != 0) check("b_start_spacing", cyc - last_b, int'(e.gap));
      end
      last_b = cyc;
    end
    if (errb) check("b_unexpected_err", 1, 0);
  end

  task automatic pa(input int s, input logic last, input logic [7:0] b);
    qa[s].push_back({last, b});
  endtask

  task automatic ea(input int s, input logic [7:0] b);
    expa_q.push_back({3'(s), b, 8'd0});
  endtask

  task automatic wait_tx_a(input logic [7:0] b, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ifa.tx_start && ifa.tx_data == b) && n < 1000);
    if (n >= 1000) check({nm, "_wait_tx"}, 0, int'(b));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((expa_q.size() != 0 || expb_q.size() != 0 || gva || gvb) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({nm, "_drain_left"}, expa_q.size() + expb_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run still active, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_grant_valid", int'(gva), 0);
    check("rst_grant_idx", int'(gia), 0);
    check("rst_err", int'(erra), 0);
    check("rst_tx_start", int'(ifa.tx_start), 0);
    check("rst_tx_data", int'(ifa.tx_data), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: five-byte packet from src0, src2 waits through the gap.
    pa(0, 0, 8'h01); pa(0, 0, 8'hAA); pa(0, 0, 8'hBB); pa(0, 0, 8'hCC); pa(0, 1, 8'hDD);
    pa(2, 1, 8'h55);
    ea(0, 8'h01); ea(0, 8'hAA); ea(0, 8'hBB); ea(0, 8'hCC); ea(0, 8'hDD); ea(2, 8'h55);
    wait_tx_a(8'hDD, "t1");
    n = 0;
    do begin
      @(negedge clk);
      if (!gva) n++;
    end while (!gva && n < 100);
    check("t1_gap_plus_arb", n, 17);
    drain("t1");

    // 2: three simultaneous 2-byte packets, twice.
    pa(0, 0, 8'hA0); pa(0, 1, 8'hA1); pa(1, 0, 8'hB0); pa(1, 1, 8'hB1); pa(2, 0, 8'hC0); pa(2, 1, 8'hC1);
    ea(0, 8'hA0); ea(0, 8'hA1); ea(1, 8'hB0); ea(1, 8'hB1); ea(2, 8'hC0); ea(2, 8'hC1);
    drain("t2a");
    pa(0, 0, 8'hD0); pa(0, 1, 8'hD1); pa(1, 0, 8'hE0); pa(1, 1, 8'hE1); pa(2, 0, 8'hF0); pa(2, 1, 8'hF1);
    ea(0, 8'hD0); ea(0, 8'hD1); ea(1, 8'hE0); ea(1, 8'hE1); ea(2, 8'hF0); ea(2, 8'hF1);
    drain("t2b");

    // 3: src1 back-to-back, src2 arrives mid-packet and wins the next slot.
    pa(1, 0, 8'h31); pa(1, 0, 8'h32); pa(1, 1, 8'h33); pa(1, 0, 8'h34); pa(1, 1, 8'h35);
    ea(1, 8'h31); ea(1, 8'h32); ea(1, 8'h33); ea(2, 8'h41); ea(1, 8'h34); ea(1, 8'h35);
    wait_tx_a(8'h31, "t3");
    pa(2, 1, 8'h41);
    drain("t3");

    // 4: src0 stalls after one byte; abort after 100 stall cycles, then src1.
    pa(0, 0, 8'h50); pa(1, 1, 8'h60);
    ea(0, 8'h50); ea(1, 8'h60);
    wait_tx_a(8'h50, "t4");
    n = 0;
    do begin
      @(negedge clk);
      if (!erra && gva && !ifa.tx_busy) n++;
    end while (!erra && n < 300);
    check("t4_stall_cycles", n, 100);
    check("t4_err_pulse", int'(erra), 1);
    check("t4_grant_dropped", int'(gva), 0);
    @(negedge clk);
    check("t4_err_one_cycle", int'(erra), 0);
    drain("t4");

    // 5: reset mid-packet, then src0 is re-granted ahead of src2.
    pa(0, 0, 8'h10); pa(0, 0, 8'h11); pa(0, 1, 8'h12);
    ea(0, 8'h10); ea(0, 8'h11); ea(0, 8'h12); ea(2, 8'h30);
    wait_tx_a(8'h10, "t5");
    resetn = 1'b0;
    pa(2, 1, 8'h30);
    @(negedge clk);
    check("t5_rst_grant_valid", int'(gva), 0);
    check("t5_rst_grant_idx", int'(gia), 0);
    check("t5_rst_tx_start", int'(ifa.tx_start), 0);
    check("t5_rst_tx_data", int'(ifa.tx_data), 0);
    check("t5_rst_err", int'(erra), 0);
    check("t5_rst_ready", int'(ifa.src_ready), 0);
    resetn = 1'b1;
    drain("t5");

    // 6: no-gap instance, single-byte packets from src2 back-to-back.
    qb[2].push_back({1'b1, 8'h70}); qb[2].push_back({1'b1, 8'h71}); qb[2].push_back({1'b1, 8'h72});
    expb_q.push_back({3'd2, 8'h70, 8'd0});
    expb_q.push_back({3'd2, 8'h71, 8'(BUSY_B + 2)});
    expb_q.push_back({3'd2, 8'h72, 8'(BUSY_B + 2)});
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
